// File: rtl/johnson_pkg.sv
// ============================================================================
// Module      : johnson_pkg
// Description : Johnson-code constants and helpers (legality check, next code)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package johnson_pkg;

  // Widest Johnson code the helpers accept; callers zero-extend narrower codes.
  localparam int unsigned JC_MAX_W = 64;

  localparam logic [JC_MAX_W-1:0] JC_ZERO = '0;

  function automatic logic [JC_MAX_W-1:0] jc_mask(input int unsigned w);
    logic [JC_MAX_W-1:0] m;
    if (w >= JC_MAX_W) m = '1;
    else               m = (JC_MAX_W'(1) << w) - JC_MAX_W'(1);
    return m;
  endfunction

  // Legal codes are 0..01..1 or its complement within the low w bits.
  function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] jc,
                                       input int unsigned         w);
    logic [JC_MAX_W-1:0] m;
    logic [JC_MAX_W-1:0] v;
    logic [JC_MAX_W-1:0] nv;
    m  = jc_mask(w);
    v  = jc & m;
    nv = ~jc & m;
    return (((v & (v + JC_MAX_W'(1))) & m) == '0) ||
           (((nv & (nv + JC_MAX_W'(1))) & m) == '0);
  endfunction

  function automatic logic [JC_MAX_W-1:0] jc_next(input logic [JC_MAX_W-1:0] jc,
                                                  input int unsigned         w);
    logic msb;
    msb = |(jc & (JC_MAX_W'(1) << (w - 1)));
    return ((jc << 1) | JC_MAX_W'(~msb)) & jc_mask(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_dff_chain_arn.sv
// ============================================================================
// Module      : sync_dff_chain_arn
// Description : N-stage, W-bit flop synchronizer, async active-low reset to 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_dff_chain_arn #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [N-1:0][W-1:0] r_stage;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_stage <= '0;
    else          r_stage <= {r_stage[N-2:0], i_d};
  end

  assign o_q = r_stage[N-1];

endmodule

`default_nettype wire

// File: rtl/johnson_ptr_sync.sv
// ============================================================================
// Module      : johnson_ptr_sync
// Description : Synchronizes a remote Johnson pointer, filters illegal samples
//               and reports them (pulse, sticky flag, saturating counter)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_ptr_sync
  import johnson_pkg::*;
#(
  parameter int    JCW           = 10,
  parameter int    SYNC_STAGES   = 3,
  parameter int    CNT_W         = 8,
  parameter string INSTANCE_NAME = ""
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [JCW-1:0]   i_remote_jc,
  input  logic             i_clr_err,
  output logic [JCW-1:0]   o_jc_sync,
  output logic             o_jc_valid,
  output logic             o_illegal,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam int         WARM_W    = $clog2(SYNC_STAGES + 1);
  localparam [WARM_W-1:0] c_warm_end = WARM_W'(SYNC_STAGES);
  localparam [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};

  if (SYNC_STAGES < 2) begin : g_chk_sync_stages
    $fatal(1, "%s: SYNC_STAGES must be >= 2", INSTANCE_NAME);
  end
  if (JCW < 2) begin : g_chk_jcw
    $fatal(1, "%s: JCW must be >= 2", INSTANCE_NAME);
  end

  logic [JCW-1:0]   w_s_jc;
  logic             w_legal;
  logic             w_flag;
  logic [JCW-1:0]   r_jc_sync;
  logic             r_valid;
  logic [WARM_W-1:0] r_warm_cnt;
  logic             r_illegal;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  sync_dff_chain_arn #(
    .N (SYNC_STAGES),
    .W (JCW)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_remote_jc),
    .o_q     (w_s_jc)
  );

  assign w_legal = jc_is_legal(JC_MAX_W'(w_s_jc), JCW);
  // Illegal samples are only reported once the chain holds real remote data.
  assign w_flag  = r_valid && !w_legal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_jc_sync  <= JC_ZERO[JCW-1:0];
      r_valid    <= 1'b0;
      r_warm_cnt <= '0;
      r_illegal  <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_legal) r_jc_sync <= w_s_jc;

      if (!r_valid) begin
        if (r_warm_cnt == c_warm_end) r_valid    <= 1'b1;
        else                          r_warm_cnt <= r_warm_cnt + 1'b1;
      end

      r_illegal <= w_flag;

      if (i_clr_err) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else if (w_flag) begin
        r_sticky <= 1'b1;
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_jc_sync     = r_jc_sync;
  assign o_jc_valid    = r_valid;
  assign o_illegal     = r_illegal;
  assign o_err_sticky  = r_sticky;
  assign o_illegal_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_johnson_ptr_sync.sv
// ============================================================================
// Module      : tb_johnson_ptr_sync
// Description : Directed self-checking bench for johnson_ptr_sync
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_johnson_ptr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] remote_jc;
  logic       clr_err;
  logic [9:0] jc_sync;
  logic       jc_valid;
  logic       illegal;
  logic       err_sticky;
  logic [7:0] illegal_cnt;

  int n_cmp = 0;
  int n_err = 0;

  johnson_ptr_sync #(
    .JCW           (10),
    .SYNC_STAGES   (3),
    .CNT_W         (8),
    .INSTANCE_NAME ("dut")
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_remote_jc   (remote_jc),
    .i_clr_err     (clr_err),
    .o_jc_sync     (jc_sync),
    .o_jc_valid    (jc_valid),
    .o_illegal     (illegal),
    .o_err_sticky  (err_sticky),
    .o_illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [9:0] walk [21] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                            10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF, 10'h3FE,
                            10'h3FC, 10'h3F8, 10'h3F0, 10'h3E0, 10'h3C0, 10'h380,
                            10'h300, 10'h200, 10'h000};
  logic [9:0] drv [48];
  int         pulses;
  int         walk_bad;

  initial begin
    rst_n     = 1'b0;
    remote_jc = 10'h155;
    clr_err   = 1'b0;

    // 1. reset state, then warm-up with an illegal sample that must be masked
    tick(2);
    check("rst_jc_sync", 32'(jc_sync), 32'h0);
    check("rst_valid", 32'(jc_valid), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_sticky", 32'(err_sticky), 32'h0);
    check("rst_cnt", 32'(illegal_cnt), 32'h0);
    rst_n = 1'b1;
    tick(1);
    remote_jc = 10'h000;
    tick(2);
    check("warm_valid_e3", 32'(jc_valid), 32'h0);
    tick(1);
    check("warm_valid_e4", 32'(jc_valid), 32'h1);
    check("warm_illegal_e4", 32'(illegal), 32'h0);
    check("warm_jc_hold", 32'(jc_sync), 32'h0);
    tick(1);
    check("warm_illegal_e5", 32'(illegal), 32'h0);
    check("warm_cnt", 32'(illegal_cnt), 32'h0);
    check("warm_sticky", 32'(err_sticky), 32'h0);

    // 2. single step latency
    tick(2);
    remote_jc = 10'h001;
    tick(3);
    check("lat_e3", 32'(jc_sync), 32'h000);
    tick(1);
    check("lat_e4", 32'(jc_sync), 32'h001);
    check("lat_illegal", 32'(illegal), 32'h0);

    // 3. walk all 20 states, one per 2 cycles
    walk_bad = 0;
    for (int c = 0; c < 48; c++) begin
      drv[c]    = walk[(c / 2 > 20) ? 20 : c / 2];
      remote_jc = drv[c];
      tick(1);
      if (c >= 3) check("walk_jc", 32'(jc_sync), 32'(drv[c-3]));
      else        check("walk_jc_pre", 32'(jc_sync), 32'h001);
      if (illegal !== 1'b0) walk_bad++;
    end
    check("walk_no_pulse", 32'(walk_bad), 32'h0);
    check("walk_cnt", 32'(illegal_cnt), 32'h0);

    // 4. illegal 0x005 for three cycles from a 0x001 output
    remote_jc = 10'h001;
    tick(4);
    check("ill_start", 32'(jc_sync), 32'h001);
    remote_jc = 10'h005;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) remote_jc = 10'h003;
      tick(1);
      if (illegal === 1'b1) pulses++;
      if (c == 5) check("ill_hold", 32'(jc_sync), 32'h001);
      if (c == 6) check("ill_recover", 32'(jc_sync), 32'h003);
    end
    check("ill_pulses", 32'(pulses), 32'd3);
    check("ill_cnt", 32'(illegal_cnt), 32'd3);
    check("ill_sticky", 32'(err_sticky), 32'h1);

    // 5. persistent illegal value saturates; clear wins over the sample
    remote_jc = 10'h2A5;
    tick(300);
    check("sat_cnt", 32'(illegal_cnt), 32'd255);
    check("sat_sticky", 32'(err_sticky), 32'h1);
    check("sat_hold", 32'(jc_sync), 32'h003);
    tick(1);
    check("sat_stays", 32'(illegal_cnt), 32'd255);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_cnt", 32'(illegal_cnt), 32'h0);
    check("clr_sticky", 32'(err_sticky), 32'h0);
    check("clr_pulse", 32'(illegal), 32'h1);
    tick(1);
    check("resume_cnt", 32'(illegal_cnt), 32'd1);
    check("resume_sticky", 32'(err_sticky), 32'h1);

    // 6. asynchronous reset mid-operation
    remote_jc = 10'h3FF;
    tick(4);
    check("pre_rst_jc", 32'(jc_sync), 32'h3FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_jc", 32'(jc_sync), 32'h0);
    check("arst_valid", 32'(jc_valid), 32'h0);
    check("arst_cnt", 32'(illegal_cnt), 32'h0);
    check("arst_sticky", 32'(err_sticky), 32'h0);
    check("arst_illegal", 32'(illegal), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("rewarm_e3", 32'(jc_valid), 32'h0);
    tick(1);
    check("rewarm_e4", 32'(jc_valid), 32'h1);
    check("rewarm_jc", 32'(jc_sync), 32'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/johnson_ptr_sync.md
Name: johnson_ptr_sync

Overview:
Receives a Johnson-coded FIFO pointer from the remote clock domain and synchronizes it into the local domain. Checks each synchronized sample for Johnson-code legality and presents a registered, always-legal Johnson code. Its output feeds the local Johnson-to-binary converter directly. It also reports illegal samples through a pulse, a sticky flag and a saturating counter.

Parameters:
JCW, 10, Johnson code width; the code has 2*JCW states.
SYNC_STAGES, 3, number of synchronizer flops; must be at least 2.
CNT_W, 8, width of the illegal-sample counter.
INSTANCE_NAME, "", debug/assertion label only.

Ports:
i_clk  input  1  local clock
i_rst_n  input  1  reset, asynchronous assert, active-low
i_remote_jc  input  JCW  Johnson pointer from the remote domain; asynchronous to i_clk
i_clr_err  input  1  synchronous clear of the counter and sticky flag
o_jc_sync  output  JCW  registered, legal Johnson code; feeds the Johnson-to-binary stage
o_jc_valid  output  1  high once synchronizer warm-up has completed
o_illegal  output  1  one-cycle pulse per illegal sample
o_err_sticky  output  1  set on any counted illegal sample
o_illegal_cnt  output  CNT_W  saturating count of illegal samples

Behaviour:
- Reset and clocking:
  - Single clock i_clk.
  - Asynchronous active-low reset i_rst_n.
  - All flops clear to 0 on reset assertion: sync chain, o_jc_sync, o_jc_valid, o_illegal, o_err_sticky, o_illegal_cnt, warm-up counter.
- Sync chain: i_remote_jc passes through SYNC_STAGES flops. Call the last stage s_jc.
- Legality of s_jc. It is legal iff either condition holds:
  - s_jc has the form 0..01..1, i.e. (s_jc & (s_jc+1)) == 0.
  - ~s_jc has that form.
  - All-zero and all-one codes are legal.
- Output register:
  - If s_jc is legal: o_jc_sync <= s_jc.
  - If s_jc is illegal: o_jc_sync holds its value.
  - A Johnson code changes one bit per step, so a mid-transition sample is always the old or new code. Multi-step advances between samples are legal and are not flagged.
- Latency: a stable change on i_remote_jc appears on o_jc_sync after SYNC_STAGES+1 rising edges.
- Warm-up:
  - A counter runs from reset release.
  - o_jc_valid rises on the (SYNC_STAGES+1)th rising edge after release and stays high until the next reset.
  - During warm-up, illegal samples are masked: the output still holds, but there is no pulse, no count and no sticky.
- Error reporting, when o_jc_valid=1 and s_jc is illegal:
  - o_illegal=1 for that cycle.
  - o_err_sticky <= 1.
  - o_illegal_cnt increments, saturating at 2^CNT_W-1.
  - A persistent illegal value counts once per cycle.
- Clear:
  - i_clr_err=1 sets o_illegal_cnt to 0 and o_err_sticky to 0 on the next edge.
  - Clear wins over a simultaneous illegal sample.
  - o_illegal still pulses in that cycle.
- Reset mid-operation: all outputs drop to 0 immediately, with no clock needed. Warm-up restarts on release.
- Assertions (simulation only, tagged with INSTANCE_NAME):
  - SYNC_STAGES >= 2.
  - JCW >= 2.

Decomposition:
- Package johnson_pkg holds:
  - function jc_is_legal(logic [JCW-1:0]), parameterized via a parameterized class or a max-width argument.
  - function jc_next for bench and upstream use.
  - localparam JC_ZERO.
- One sub-module: sync_dff_chain_arn.
  - Generic N-stage, W-bit synchronizer.
  - Asynchronous active-low reset, reset value 0.
- The legality check, warm-up counter and error logic stay in johnson_ptr_sync.

Test Plan:
Defaults JCW=10, SYNC_STAGES=3, CNT_W=8.
1. Reset held, i_remote_jc=0x155 -> all outputs 0. Release reset -> o_jc_valid=1 on the 4th edge; o_illegal stays 0 (masked).
2. After warm-up, step i_remote_jc 0x000->0x001 at edge t -> o_jc_sync=0x001 from edge t+4; no error.
3. Walk all 20 states (0x000, 0x001, 0x003 ... 0x3FF, 0x3FE ... 0x200, 0x000) one per 2 cycles -> o_jc_sync follows each state with latency 4; o_illegal_cnt=0 throughout.
4. From o_jc_sync=0x001, drive illegal 0x005 for 3 cycles, then 0x003 -> o_jc_sync holds 0x001 then becomes 0x003; three o_illegal pulses; o_illegal_cnt=3; o_err_sticky=1.
5. Hold 0x2A5 for 300 valid cycles -> o_illegal_cnt saturates at 255. Pulse i_clr_err while still illegal -> count=0 and sticky=0 next edge, then count resumes at 1.
6. With o_jc_sync=0x3FF, assert i_rst_n low between clock edges -> o_jc_sync=0 and o_jc_valid=0 immediately. After release, o_jc_valid re-rises after 4 edges.
